// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        WRITE,
        HOLD,
        RUN,
        ERR
    } state_e;

    // Byte address of word k in the target memory; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] k);
        return base + (k << 2);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction memory write port out.
interface imem_loader_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_data;
    logic        i_mem_write;

    // Loader side.
    modport slave (
        input  s_data, s_valid,
        output s_ready, i_mem_addr, i_mem_data, i_mem_write
    );

    // Host / memory side.
    modport master (
        output s_data, s_valid,
        input  s_ready, i_mem_addr, i_mem_data, i_mem_write
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream. The word is
// presented combinationally in the same cycle its last byte transfers, so the
// parent can register the memory write on that very edge.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        r,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    input  logic        ready_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] idx_q;
    // Only the three lower bytes need storage; the top byte comes straight from data_i.
    logic [23:0]      shreg_q;
    logic             fire;

    assign fire         = valid_i && ready_i;
    assign word_valid_o = fire && (idx_q == LAST_IDX);
    assign word_o       = {data_i, shreg_q};

    // Capture each accepted byte into its lane and advance the index (wraps 3->0).
    always_ff @(posedge clk) begin
        if (r) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else if (fire) begin
            idx_q <= idx_q + 1'b1;
            unique case (idx_q)
                2'd0:    shreg_q[7:0]   <= data_i;
                2'd1:    shreg_q[15:8]  <= data_i;
                2'd2:    shreg_q[23:16] <= data_i;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a word count and that many words from a byte stream,
// writes them to instruction memory, then releases the CPU from reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         r,
    imem_loader_if.slave bus,
    output logic         cpu_r,
    output logic         busy,
    output logic         done,
    output logic         err
);

    state_e      state_q;
    logic        s_ready_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] n_q;
    logic [31:0] k_q;
    logic [31:0] cnt_q;
    logic        cpu_r_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [31:0] word;
    logic        word_vld;

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .r            (r),
        .data_i       (bus.s_data),
        .valid_i      (bus.s_valid),
        .ready_i      (s_ready_q),
        .word_o       (word),
        .word_valid_o (word_vld)
    );

    assign bus.s_ready     = s_ready_q;
    assign bus.i_mem_write = we_q;
    assign bus.i_mem_addr  = addr_q;
    assign bus.i_mem_data  = data_q;
    assign cpu_r           = cpu_r_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;

    // Loader FSM; every output is a register updated with the state transition.
    always_ff @(posedge clk) begin
        if (r) begin
            state_q   <= HDR;
            s_ready_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= BASE_ADDR;
            data_q    <= '0;
            n_q       <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            cpu_r_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                HDR: begin
                    s_ready_q <= 1'b1;
                    if (word_vld) begin
                        n_q <= word;
                        k_q <= '0;
                        if (word == '0) begin
                            state_q   <= HOLD;
                            s_ready_q <= 1'b0;
                            cnt_q     <= '0;
                        end else if (word > MAX_WORDS) begin
                            state_q   <= ERR;
                            s_ready_q <= 1'b0;
                            err_q     <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (word_vld) begin
                        addr_q    <= word_addr(BASE_ADDR, k_q);
                        data_q    <= word;
                        we_q      <= 1'b1;
                        s_ready_q <= 1'b0;
                        state_q   <= WRITE;
                    end
                end
                WRITE: begin
                    k_q <= k_q + 32'd1;
                    if (k_q + 32'd1 == n_q) begin
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        state_q   <= LOAD;
                        s_ready_q <= 1'b1;
                    end
                end
                HOLD: begin
                    // Keep the CPU in reset for RELEASE_CYCLES cycles after loading.
                    if (cnt_q == RELEASE_CYCLES - 1) begin
                        state_q <= RUN;
                        cpu_r_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                RUN, ERR: ;
                default: state_q <= HDR;
            endcase
        end
    end

endmodule
